// File: rtl/pipe_stage_pkg.sv
// +------------------------------------------------------------------+
// | pipe_stage_pkg : widths, control-bit maps and kill masks          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package pipe_stage_pkg;

  localparam int DATA_W_DEFAULT = 64;
  localparam int CTRL_W_DEFAULT = 16;

  localparam int          PERF_W   = 16;
  localparam logic [15:0] PERF_MAX = 16'hFFFF;

  // ID/EX control-bit index map
  localparam int IDEX_ALUOP_LSB   = 0;
  localparam int IDEX_ALUOP_W     = 5;
  localparam int IDEX_MEMREAD     = 5;
  localparam int IDEX_MEMWRITE    = 6;
  localparam int IDEX_REGWRITE    = 7;
  localparam int IDEX_TRAP        = 8;
  localparam int IDEX_CANERR_LSB  = 9;
  localparam int IDEX_CANERR_W    = 3;
  localparam int IDEX_REGDST      = 12;
  localparam int IDEX_ALUSRC      = 13;
  localparam int IDEX_MEMTOREG    = 14;
  localparam int IDEX_LINK        = 15;

  typedef struct packed {
    logic       link;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] can_err;
    logic       trap;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic [4:0] alu_op;
  } idex_ctrl_t;

  function automatic logic [15:0] field_mask(input int lsb, input int width);
    logic [15:0] ones;
    ones = (16'h0001 << width) - 16'h0001;
    return ones << lsb;
  endfunction

  // Only side-effecting bits need killing; steering bits are harmless.
  localparam logic [15:0] IFID_KILL_MASK = 16'h0000;
  localparam logic [15:0] IDEX_KILL_MASK =
      field_mask(IDEX_ALUOP_LSB, IDEX_ALUOP_W) |
      field_mask(IDEX_MEMREAD, 1) | field_mask(IDEX_MEMWRITE, 1) |
      field_mask(IDEX_REGWRITE, 1) | field_mask(IDEX_TRAP, 1) |
      field_mask(IDEX_CANERR_LSB, IDEX_CANERR_W);
  localparam logic [15:0] EXM_KILL_MASK  = 16'h0077;
  localparam logic [15:0] MWB_KILL_MASK  = 16'h0001;

endpackage

`default_nettype wire

// File: rtl/pipe_perf_ctr.sv
// +------------------------------------------------------------------+
// | pipe_perf_ctr : 16-bit saturating event counter with clear        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module pipe_perf_ctr
  import pipe_stage_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic [PERF_W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != PERF_MAX)) begin
      count <= count + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// +------------------------------------------------------------------+
// | pipe_stage_reg : elastic pipeline register, 2-entry skid buffer   |
// | Optional perf counters under PIPE_STAGE_PERF_EN. Rev 1.0          |
// +------------------------------------------------------------------+
`default_nettype none

module pipe_stage_reg
  import pipe_stage_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEFAULT,
  parameter int                CTRL_W    = CTRL_W_DEFAULT,
  parameter logic [CTRL_W-1:0] KILL_MASK = {CTRL_W{1'b1}},
  parameter logic [CTRL_W-1:0] CTRL_RST  = {CTRL_W{1'b0}}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [15:0]       perf_bubbles,
  output logic [15:0]       perf_stalls
`endif
);

  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic              s_valid;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;

  logic w_in_fire;
  logic w_m_free;

  // in_ready comes straight from the skid flop: no path from out_ready.
  assign in_ready  = ~s_valid;
  assign w_in_fire = in_valid & in_ready;
  assign w_m_free  = ~m_valid | out_ready;

  assign out_valid = m_valid;
  assign out_ctrl  = m_ctrl & ~(KILL_MASK & {CTRL_W{~m_valid}});
  assign out_data  = m_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_ctrl  <= CTRL_RST;
      m_data  <= '0;
      s_valid <= 1'b0;
      s_ctrl  <= CTRL_RST;
      s_data  <= '0;
    end else if (flush) begin
      // Payloads hold so exception logic can still read restart info.
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (w_m_free) begin
      if (s_valid) begin
        m_valid <= 1'b1;
        m_ctrl  <= s_ctrl;
        m_data  <= s_data;
        s_valid <= 1'b0;
      end else if (w_in_fire) begin
        m_valid <= 1'b1;
        m_ctrl  <= in_ctrl;
        m_data  <= in_data;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      s_valid <= 1'b1;
      s_ctrl  <= in_ctrl;
      s_data  <= in_data;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_perf_ctr u_bubble_ctr (
    .clock (clock),
    .reset (reset),
    .clr   (perf_clr),
    .inc   (~m_valid & ~flush),
    .count (perf_bubbles)
  );

  pipe_perf_ctr u_stall_ctr (
    .clock (clock),
    .reset (reset),
    .clr   (perf_clr),
    .inc   (m_valid & ~out_ready),
    .count (perf_stalls)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// +------------------------------------------------------------------+
// | tb_pipe_stage_reg : scoreboard bench for pipe_stage_reg           |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_pipe_stage_reg;

  localparam int          DW   = 64;
  localparam int          CW   = 16;
  localparam logic [15:0] KM   = 16'hFF00;
  localparam logic [15:0] CRST = 16'h0F0F;

  logic          clock;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic          perf_clr;
  logic [15:0]   perf_bubbles;
  logic [15:0]   perf_stalls;
`endif

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } ent_t;

  ent_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  pipe_stage_reg #(
    .DATA_W    (DW),
    .CTRL_W    (CW),
    .KILL_MASK (KM),
    .CTRL_RST  (CRST)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_clr     (perf_clr),
    .perf_bubbles (perf_bubbles),
    .perf_stalls  (perf_stalls)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  // Monitor: samples mid-cycle, pops on output handshake, pushes on input handshake.
  initial begin
    ent_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_q.delete();
        continue;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_output", {63'd0, out_valid}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", out_data, e.data);
          chk("sb_ctrl", {48'd0, out_ctrl}, {48'd0, e.ctrl});
        end
      end
      if (flush) begin
        exp_q.delete();
      end else if (in_valid && in_ready) begin
        e.ctrl = in_ctrl;
        e.data = in_data;
        exp_q.push_back(e);
      end
    end
  end

  initial begin
    clock = 1'b0;
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, '0);
`ifdef PIPE_STAGE_PERF_EN
    perf_clr = 1'b0;
`endif
    #2;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_ctrl",  {48'd0, out_ctrl},  64'h000F);
    step();
    reset = 1'b0;

    // Streaming 1..8 with 1-cycle latency, no bubbles.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'h0100 + 16'(i), 64'(i));
      step();
      chk("stream_valid", {63'd0, out_valid}, 64'd1);
      chk("stream_data",  out_data, 64'(i));
    end
    drive(1'b0, '0, '0);
    step();
    chk("stream_drained", {63'd0, out_valid}, 64'd0);

    // Skid: A into M, B into S, C refused.
    out_ready = 1'b0;
    drive(1'b1, 16'h0A0A, 64'hA);
    step();
    chk("skid_ready_after_a", {63'd0, in_ready}, 64'd1);
    drive(1'b1, 16'h0B0B, 64'hB);
    step();
    chk("skid_ready_full", {63'd0, in_ready}, 64'd0);
    drive(1'b1, 16'h0C0C, 64'hC);
    for (int i = 0; i < 3; i++) step();
    chk("skid_hold_ready", {63'd0, in_ready}, 64'd0);
    chk("skid_hold_data",  out_data, 64'hA);
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    step();
    chk("skid_release_b",     out_data, 64'hB);
    chk("skid_release_ready", {63'd0, in_ready}, 64'd1);
    step();
    chk("skid_empty", {63'd0, out_valid}, 64'd0);

    // Flush while full: C dropped, A data visible, ctrl masked.
    out_ready = 1'b0;
    drive(1'b1, 16'hA5C3, 64'hA2);
    step();
    drive(1'b1, 16'hB5B5, 64'hB2);
    step();
    flush = 1'b1;
    drive(1'b1, 16'hC5C5, 64'hC2);
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_out_data",  out_data, 64'hA2);
    chk("flush_out_ctrl",  {48'd0, out_ctrl}, 64'h00C3);
    chk("flush_in_ready",  {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    step();
    chk("flush_c_dropped", {63'd0, out_valid}, 64'd0);

    // Flush coinciding with out_ready: entry consumed, then cleared.
    drive(1'b1, 16'h3333, 64'hA3);
    step();
    drive(1'b0, '0, '0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_consume_valid", {63'd0, out_valid}, 64'd0);

    // Kill mask on an all-ones control word.
    out_ready = 1'b0;
    drive(1'b1, 16'hFFFF, 64'h55);
    step();
    drive(1'b0, '0, '0);
    chk("kill_valid_ctrl", {48'd0, out_ctrl}, 64'hFFFF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("kill_invalid_ctrl", {48'd0, out_ctrl}, 64'h00FF);
    chk("kill_invalid_data", out_data, 64'h55);

    // Reset asserted between edges while both entries are full.
    drive(1'b1, 16'h1111, 64'h11);
    step();
    drive(1'b1, 16'h2222, 64'h12);
    step();
    drive(1'b1, 16'h3333, 64'h13);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("arst_out_ctrl",  {48'd0, out_ctrl},  64'h000F);
    drive(1'b0, '0, '0);
    step();
    reset = 1'b0;
    step();
    chk("arst_after_valid", {63'd0, out_valid}, 64'd0);

`ifdef PIPE_STAGE_PERF_EN
    out_ready = 1'b1;
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    step();
    step();
    drive(1'b1, 16'h4444, 64'h44);
    step();
    drive(1'b0, '0, '0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("perf_bubbles", {48'd0, perf_bubbles}, 64'd3);
    chk("perf_stalls",  {48'd0, perf_stalls},  64'd5);
    for (int i = 0; i < 70000; i++) step();
    chk("perf_stalls_sat", {48'd0, perf_stalls}, 64'hFFFF);
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    chk("perf_clr_stalls",  {48'd0, perf_stalls},  64'd0);
    chk("perf_clr_bubbles", {48'd0, perf_bubbles}, 64'd0);
    out_ready = 1'b1;
    step();
    step();
`endif

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
